// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multicycle CPU: opcodes, control-field values,
// instruction field positions and immediate sign-extension helpers.
package cpu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_LM  = 4'b0110;
   localparam logic [3:0] OP_SM  = 4'b0111;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1100;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_ADC   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_NAND  = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM6 = 2'b10;
   localparam logic [1:0] SRCB_IMM9 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_A      = 2'b10;
   localparam logic [1:0] PCSRC_HOLD   = 2'b11;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RA_MSB = 11;
   localparam int RA_LSB = 9;
   localparam int RB_MSB = 8;
   localparam int RB_LSB = 6;
   localparam int RC_MSB = 5;
   localparam int RC_LSB = 3;
   localparam int CZ_MSB = 1;
   localparam int CZ_LSB = 0;

   function automatic logic [15:0] sext6(input logic [5:0] v);
      return {{10{v[5]}}, v};
   endfunction

   function automatic logic [15:0] sext9(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Eight 16-bit general-purpose registers: two asynchronous read ports,
// one synchronous write port, synchronous clear.
module regfile_8x16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [2:0]  ra1,
   input  logic [2:0]  ra2,
   input  logic [2:0]  wa,
   input  logic [15:0] wd,
   output logic [15:0] rd1,
   output logic [15:0] rd2
);

   logic [15:0] rf [8];

   // Reset wins over a pending write so an interrupted writeback never lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            rf[i] <= '0;
         end
      end else if (we) begin
         rf[wa] <= wd;
      end
   end

   assign rd1 = rf[ra1];
   assign rd2 = rf[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle datapath for the 16-bit CPU: executes one control word per cycle
// and reports opcode, condition bits and the ALU zero test back to the controller.
import cpu_pkg::*;

module multicycle_datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcen,
   input  logic        iord,
   input  logic        irwrite,
   input  logic        memwrite,
   input  logic        regwrite,
   input  logic        regdst,
   input  logic        memtoreg,
   input  logic        alusrca,
   input  logic [1:0]  alusrcb,
   input  logic [1:0]  pcsrc,
   input  logic [2:0]  alucontrol,
   output logic [3:0]  op,
   output logic [1:0]  cz,
   output logic        zero,
   output logic        cflag,
   output logic        zflag,
   output logic [15:0] mem_adr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata
);

   logic [15:0] pc, ir, mdr, a_reg, b_reg, alu_out;
   logic        c_pend, z_pend;
   logic [15:0] rd1, rd2, wd3;
   logic [2:0]  ra, rb, rc, wa3;
   logic [15:0] imm6_ext, imm9_ext;
   logic [15:0] src_a, src_b, alu_result, pc_next;
   logic [16:0] sum;
   logic        alu_carry;

   assign op       = ir[OP_MSB:OP_LSB];
   assign cz       = ir[CZ_MSB:CZ_LSB];
   assign ra       = ir[RA_MSB:RA_LSB];
   assign rb       = ir[RB_MSB:RB_LSB];
   assign rc       = ir[RC_MSB:RC_LSB];
   assign imm6_ext = sext6(ir[5:0]);
   assign imm9_ext = sext9(ir[8:0]);

   assign wa3 = regdst ? rc : ra;
   assign wd3 = memtoreg ? mdr : alu_out;

   regfile_8x16 u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (regwrite),
      .ra1   (ra),
      .ra2   (rb),
      .wa    (wa3),
      .wd    (wd3),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   assign src_a = alusrca ? a_reg : pc;

   always_comb begin
      src_b = b_reg;
      case (alusrcb)
         SRCB_B:    src_b = b_reg;
         SRCB_ONE:  src_b = 16'd1;
         SRCB_IMM6: src_b = imm6_ext;
         SRCB_IMM9: src_b = imm9_ext;
         default:   src_b = b_reg;
      endcase
   end

   // Arithmetic runs 17 bits wide; bit 16 is the carry (for SUB: no-borrow).
   always_comb begin
      sum        = '0;
      alu_result = '0;
      alu_carry  = 1'b0;
      case (alucontrol)
         ALU_ADD: begin
            sum        = {1'b0, src_a} + {1'b0, src_b};
            alu_result = sum[15:0];
            alu_carry  = sum[16];
         end
         ALU_ADC: begin
            sum        = {1'b0, src_a} + {1'b0, src_b} + {16'd0, cflag};
            alu_result = sum[15:0];
            alu_carry  = sum[16];
         end
         ALU_SUB: begin
            sum        = {1'b0, src_a} + {1'b0, ~src_b} + 17'd1;
            alu_result = sum[15:0];
            alu_carry  = sum[16];
         end
         ALU_NAND:  alu_result = ~(src_a & src_b);
         ALU_PASSB: alu_result = src_b;
         default:   alu_result = '0;
      endcase
   end

   assign zero = (alu_result == 16'd0);

   always_comb begin
      pc_next = pc;
      case (pcsrc)
         PCSRC_ALU:    pc_next = alu_result;
         PCSRC_ALUOUT: pc_next = alu_out;
         PCSRC_A:      pc_next = a_reg;
         PCSRC_HOLD:   pc_next = pc;
         default:      pc_next = pc;
      endcase
   end

   // Operand latches refresh every cycle; PC, IR and flags only on their enables.
   // A load writeback tests MDR for zero and leaves the carry alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         ir      <= '0;
         mdr     <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         alu_out <= '0;
         c_pend  <= 1'b0;
         z_pend  <= 1'b0;
         cflag   <= 1'b0;
         zflag   <= 1'b0;
      end else begin
         a_reg   <= rd1;
         b_reg   <= rd2;
         mdr     <= mem_rdata;
         alu_out <= alu_result;
         c_pend  <= alu_carry;
         z_pend  <= zero;
         if (irwrite) begin
            ir <= mem_rdata;
         end
         if (pcen) begin
            pc <= pc_next;
         end
         if (regwrite) begin
            if (memtoreg) begin
               zflag <= (mdr == 16'd0);
            end else begin
               cflag <= c_pend;
               zflag <= z_pend;
            end
         end
      end
   end

   assign mem_adr   = iord ? alu_out : pc;
   assign mem_wdata = b_reg;
   assign mem_we    = memwrite;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: drives instruction-level control
// sequences and compares against an architectural model of registers, flags and PC.
module tb_multicycle_datapath;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0]  alusrcb, pcsrc;
   logic [2:0]  alucontrol;
   logic [3:0]  op;
   logic [1:0]  cz;
   logic        zero, cflag, zflag, mem_we;
   logic [15:0] mem_adr, mem_wdata, mem_rdata;

   logic [15:0] mem [256];
   logic [15:0] rf_m [8];
   logic        cf_m, zf_m;
   logic [15:0] pc_m;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_adr[7:0]];

   multicycle_datapath dut (
      .clk        (clk),
      .reset      (reset),
      .pcen       (pcen),
      .iord       (iord),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .op         (op),
      .cz         (cz),
      .zero       (zero),
      .cflag      (cflag),
      .zflag      (zflag),
      .mem_adr    (mem_adr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   // Reference ALU from the arithmetic rules: {carry, result}.
   function automatic logic [16:0] alu_ref(input logic [2:0] ctl, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
      logic [16:0] r;
      int unsigned s;
      logic [15:0] d;
      r = 17'd0;
      case (ctl)
         3'd0: begin s = a + b;       r = {s[16], s[15:0]}; end
         3'd1: begin s = a + b + cin; r = {s[16], s[15:0]}; end
         3'd2: begin d = a - b;       r = {(a >= b), d};    end
         3'd3: r = {1'b0, ~(a & b)};
         3'd4: r = {1'b0, b};
         default: r = 17'd0;
      endcase
      return r;
   endfunction

   task automatic clear_ctrl();
      pcen = 0; iord = 0; irwrite = 0; memwrite = 0; regwrite = 0;
      regdst = 0; memtoreg = 0; alusrca = 0;
      alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b000;
   endtask

   // The bench's memory commits a store at the edge, like the external RAM.
   task automatic tick();
      #1;
      if (memwrite) mem[mem_adr[7:0]] = mem_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] instr);
      mem[pc_m[7:0]] = instr;
      clear_ctrl();
      pcen = 1; irwrite = 1; alusrcb = SRCB_ONE; alucontrol = ALU_ADD; pcsrc = PCSRC_ALU;
      tick();
      clear_ctrl();
      pc_m = pc_m + 16'd1;
   endtask

   task automatic write_reg(input logic [2:0] r, input logic [15:0] val);
      fetch({OP_LW, r, 9'd0});
      mem[pc_m[7:0]] = val;
      tick();
      regwrite = 1; memtoreg = 1;
      tick();
      clear_ctrl();
      rf_m[r] = val;
      zf_m = (val == 16'd0);
   endtask

   task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
      fetch({OP_ADD, 3'd0, r, 6'd0});
      tick();
      val = mem_wdata;
   endtask

   task automatic exec_alu(input logic [2:0] ctl, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rc, output logic zero_seen);
      logic [16:0] e;
      e = alu_ref(ctl, rf_m[ra], rf_m[rb], cf_m);
      fetch({OP_ADD, ra, rb, rc, 3'b000});
      tick();
      alusrca = 1; alusrcb = SRCB_B; alucontrol = ctl;
      #1;
      zero_seen = zero;
      tick();
      clear_ctrl();
      regwrite = 1; regdst = 1;
      tick();
      clear_ctrl();
      rf_m[rc] = e[15:0];
      cf_m = e[16];
      zf_m = (e[15:0] == 16'd0);
   endtask

   task automatic test_reset();
      reset = 1;
      clear_ctrl();
      memwrite = 1;
      #1;
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 1", mem_we); end
      tick();
      tick();
      memwrite = 0;
      checks++;
      if (op !== 4'd0) begin errors++; $display("[TB] FAIL reset_op: got %h expected 0", op); end
      checks++;
      if (cz !== 2'd0) begin errors++; $display("[TB] FAIL reset_cz: got %h expected 0", cz); end
      checks++;
      if (mem_adr !== 16'd0) begin errors++; $display("[TB] FAIL reset_adr: got %h expected 0", mem_adr); end
      checks++;
      if (mem_wdata !== 16'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wdata); end
      checks++;
      if ({cflag, zflag} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {cflag, zflag}); end
      reset = 0;
      tick();
   endtask

   task automatic test_fetch();
      mem[0] = 16'h0048;
      clear_ctrl();
      pcen = 1; irwrite = 1; alusrcb = SRCB_ONE; alucontrol = ALU_ADD; pcsrc = PCSRC_ALU;
      #1;
      checks++;
      if (mem_adr !== 16'd0) begin errors++; $display("[TB] FAIL fetch_adr: got %h expected 0", mem_adr); end
      tick();
      clear_ctrl();
      pc_m = 16'd1;
      checks++;
      if ({op, cz} !== 6'd0) begin errors++; $display("[TB] FAIL fetch_opcz: got %h expected 0", {op, cz}); end
      checks++;
      if (mem_adr !== 16'd1) begin errors++; $display("[TB] FAIL fetch_pc: got %h expected 1", mem_adr); end
      fetch(16'hC7A3);
      checks++;
      if ({op, cz} !== {4'hC, 2'b11}) begin errors++; $display("[TB] FAIL fetch2_opcz: got %h expected %h", {op, cz}, {4'hC, 2'b11}); end
      checks++;
      if (mem_adr !== 16'd2) begin errors++; $display("[TB] FAIL fetch2_pc: got %h expected 2", mem_adr); end
   endtask

   task automatic test_add();
      logic zs;
      logic [15:0] v;
      write_reg(3'd1, 16'd5);
      exec_alu(ALU_ADD, 3'd1, 3'd1, 3'd0, zs);
      read_reg(3'd0, v);
      checks++;
      if (v !== 16'd10) begin errors++; $display("[TB] FAIL add_r0: got %h expected %h", v, 16'd10); end
      checks++;
      if ({cflag, zflag} !== 2'b00) begin errors++; $display("[TB] FAIL add_flags: got %b expected 00", {cflag, zflag}); end
   endtask

   task automatic test_adc_chain();
      logic zs;
      logic [15:0] v;
      write_reg(3'd1, 16'hFFFF);
      exec_alu(ALU_ADD, 3'd1, 3'd1, 3'd3, zs);
      checks++;
      if (cflag !== 1'b1) begin errors++; $display("[TB] FAIL adc_carry_in: got %b expected 1", cflag); end
      write_reg(3'd1, 16'd0);
      write_reg(3'd2, 16'd0);
      exec_alu(ALU_ADC, 3'd1, 3'd2, 3'd4, zs);
      read_reg(3'd4, v);
      checks++;
      if (v !== 16'd1) begin errors++; $display("[TB] FAIL adc_result: got %h expected 1", v); end
      checks++;
      if ({cflag, zflag} !== 2'b00) begin errors++; $display("[TB] FAIL adc_flags: got %b expected 00", {cflag, zflag}); end
   endtask

   task automatic test_nand();
      logic zs;
      logic [15:0] v;
      write_reg(3'd5, 16'hABCD);
      write_reg(3'd1, 16'hFFFF);
      write_reg(3'd2, 16'hFFFF);
      exec_alu(ALU_ADD, 3'd1, 3'd2, 3'd6, zs);
      checks++;
      if (cflag !== 1'b1) begin errors++; $display("[TB] FAIL nand_pre_carry: got %b expected 1", cflag); end
      exec_alu(ALU_NAND, 3'd1, 3'd2, 3'd5, zs);
      checks++;
      if (zs !== 1'b1) begin errors++; $display("[TB] FAIL nand_zero: got %b expected 1", zs); end
      checks++;
      if ({cflag, zflag} !== 2'b01) begin errors++; $display("[TB] FAIL nand_flags: got %b expected 01", {cflag, zflag}); end
      read_reg(3'd5, v);
      checks++;
      if (v !== 16'd0) begin errors++; $display("[TB] FAIL nand_result: got %h expected 0", v); end
   endtask

   task automatic test_alu_random();
      logic zs;
      logic [15:0] v;
      logic [2:0] ra, rb, rc, ctl;
      for (int i = 0; i < 8; i++) begin
         ctl = 3'(i);
         ra = 3'($urandom_range(0, 7));
         rb = 3'($urandom_range(0, 7));
         rc = 3'($urandom_range(0, 7));
         write_reg(ra, 16'($urandom));
         write_reg(rb, 16'($urandom));
         exec_alu(ctl, ra, rb, rc, zs);
         checks++;
         if (zs !== zf_m) begin errors++; $display("[TB] FAIL rnd_zero ctl=%0d: got %b expected %b", ctl, zs, zf_m); end
         checks++;
         if ({cflag, zflag} !== {cf_m, zf_m}) begin errors++; $display("[TB] FAIL rnd_flags ctl=%0d: got %b expected %b", ctl, {cflag, zflag}, {cf_m, zf_m}); end
         read_reg(rc, v);
         checks++;
         if (v !== rf_m[rc]) begin errors++; $display("[TB] FAIL rnd_result ctl=%0d: got %h expected %h", ctl, v, rf_m[rc]); end
      end
   endtask

   task automatic test_store_load();
      logic zs;
      logic [15:0] v;
      write_reg(3'd2, 16'h1234);
      fetch({OP_SW, 3'd0, 3'd2, 6'd7});
      tick();
      alusrcb = SRCB_IMM6; alucontrol = ALU_PASSB;
      tick();
      clear_ctrl();
      iord = 1; memwrite = 1;
      #1;
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL store_we: got %b expected 1", mem_we); end
      checks++;
      if (mem_adr !== 16'd7) begin errors++; $display("[TB] FAIL store_adr: got %h expected 7", mem_adr); end
      checks++;
      if (mem_wdata !== 16'h1234) begin errors++; $display("[TB] FAIL store_data: got %h expected 1234", mem_wdata); end
      tick();
      clear_ctrl();

      write_reg(3'd3, 16'h5555);
      write_reg(3'd1, 16'hFFFF);
      exec_alu(ALU_ADD, 3'd1, 3'd1, 3'd6, zs);
      mem[7] = 16'd0;
      fetch({OP_LW, 3'd3, 3'd0, 6'd7});
      tick();
      alusrcb = SRCB_IMM6; alucontrol = ALU_PASSB;
      tick();
      clear_ctrl();
      iord = 1;
      tick();
      clear_ctrl();
      regwrite = 1; memtoreg = 1;
      tick();
      clear_ctrl();
      rf_m[3] = 16'd0;
      zf_m = 1'b1;
      checks++;
      if ({cflag, zflag} !== 2'b11) begin errors++; $display("[TB] FAIL load_flags: got %b expected 11", {cflag, zflag}); end
      read_reg(3'd3, v);
      checks++;
      if (v !== 16'd0) begin errors++; $display("[TB] FAIL load_r3: got %h expected 0", v); end
   endtask

   task automatic test_reset_mid();
      logic zs;
      logic [15:0] v;
      write_reg(3'd1, 16'hFFFF);
      exec_alu(ALU_ADD, 3'd1, 3'd1, 3'd5, zs);
      write_reg(3'd2, 16'($urandom_range(2, 65535)));
      fetch({OP_ADD, 3'd1, 3'd2, 3'd6, 3'b000});
      tick();
      alusrca = 1; alusrcb = SRCB_B; alucontrol = ALU_ADD;
      tick();
      clear_ctrl();
      mem[pc_m[7:0]] = 16'hF1FF;
      regwrite = 1; regdst = 1; pcen = 1; irwrite = 1; alusrcb = SRCB_ONE;
      reset = 1;
      tick();
      reset = 0;
      clear_ctrl();
      for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;
      cf_m = 0; zf_m = 0; pc_m = 16'd0;
      checks++;
      if ({cflag, zflag} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_flags: got %b expected 00", {cflag, zflag}); end
      checks++;
      if ({op, cz} !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_ir: got %h expected 0", {op, cz}); end
      checks++;
      if (mem_adr !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_pc: got %h expected 0", mem_adr); end
      read_reg(3'd6, v);
      checks++;
      if (v !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_r6: got %h expected 0", v); end
      read_reg(3'd5, v);
      checks++;
      if (v !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_r5: got %h expected 0", v); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'd0;
      for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;
      cf_m = 0; zf_m = 0; pc_m = 16'd0;
      reset = 1;
      clear_ctrl();
      test_reset();
      test_fetch();
      test_add();
      test_adc_chain();
      test_nand();
      test_alu_random();
      test_store_load();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
